// File: rtl/graph_build_pkg.sv
// graph_build_pkg: shared constants, slot layout and FSM encoding for the cell store path
package graph_build_pkg;
  localparam int DEPTH     = 12000;
  localparam int ADDR_W    = $clog2(DEPTH);
  localparam int NSLOT     = 16;
  localparam int SLOT_W    = 72;
  localparam int ROW_W     = NSLOT * SLOT_W;
  localparam int EVT_W     = SLOT_W - 1;
  localparam int IDX_W     = $clog2(NSLOT);
  localparam int RD_LAT    = 2;
  localparam int VALID_BIT = 71;
  localparam int TS_MSB    = 70;
  localparam int TS_LSB    = 39;
  localparam int TS_W      = TS_MSB - TS_LSB + 1;
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_READ, S_MODIFY, S_RESP} state_e;
  function automatic logic [ROW_W-1:0] put_slot(input logic [ROW_W-1:0] row,
                                                input logic [IDX_W-1:0] idx,
                                                input logic [EVT_W-1:0] evt);
    logic [ROW_W-1:0] r;
    r = row;
    r[int'(idx)*SLOT_W +: SLOT_W] = {1'b1, evt};
    return r;
  endfunction
endpackage

// File: rtl/slot_victim_sel.sv
// slot_victim_sel: picks the lowest free slot, else the oldest one (lowest index on ties)
module slot_victim_sel
  import graph_build_pkg::*;
(
  input  logic [NSLOT-1:0]      valid_i,
  input  logic [NSLOT*TS_W-1:0] ts_i,
  output logic [IDX_W-1:0]      idx_o
);
  logic [TS_W-1:0]  ts [2*NSLOT-1];
  logic [IDX_W-1:0] ix [2*NSLOT-1];
  logic [IDX_W-1:0] free_idx;
  logic             has_free;
  // heap-ordered min tree: node k has children 2k+1 (lower slots) and 2k+2
  always_comb begin
    for (int n = 0; n < NSLOT; n++) begin
      ts[NSLOT-1+n] = ts_i[n*TS_W +: TS_W];
      ix[NSLOT-1+n] = IDX_W'(n);
    end
    for (int k = NSLOT-2; k >= 0; k--) begin
      ts[k] = ts[2*k+2] < ts[2*k+1] ? ts[2*k+2] : ts[2*k+1];
      ix[k] = ts[2*k+2] < ts[2*k+1] ? ix[2*k+2] : ix[2*k+1];
    end
    has_free = 1'b0;
    free_idx = '0;
    for (int n = NSLOT-1; n >= 0; n--) begin
      if (!valid_i[n]) begin
        has_free = 1'b1;
        free_idx = IDX_W'(n);
      end
    end
  end
  assign idx_o = has_free ? free_idx : ix[0];
endmodule

// File: rtl/cell_row_updater.sv
// cell_row_updater: clears the cell store after reset, then does one read-modify-write per event
module cell_row_updater
  import graph_build_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              evt_valid,
  output logic              evt_ready,
  input  logic [ADDR_W-1:0] evt_addr,
  input  logic [EVT_W-1:0]  evt_data,
  output logic              nbr_valid,
  input  logic              nbr_ready,
  output logic [ROW_W-1:0]  nbr_row,
  output logic [EVT_W-1:0]  nbr_evt,
  output logic              init_done,
  output logic              uram_we,
  output logic [ADDR_W-1:0] uram_addr,
  output logic [ROW_W-1:0]  uram_din,
  input  logic [ROW_W-1:0]  uram_dout
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [EVT_W-1:0]  evt_q, evt_d;
  logic              evt_ready_q, evt_ready_d;
  logic              nbr_valid_q, nbr_valid_d;
  logic [ROW_W-1:0]  nbr_row_q, nbr_row_d;
  logic [EVT_W-1:0]  nbr_evt_q, nbr_evt_d;
  logic              init_done_q, init_done_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ROW_W-1:0]  din_q, din_d;
  logic [NSLOT-1:0]      slot_v;
  logic [NSLOT*TS_W-1:0] slot_ts;
  logic [IDX_W-1:0]      victim;
  for (genvar n = 0; n < NSLOT; n++) begin : g_fields
    assign slot_v[n]                = uram_dout[n*SLOT_W+VALID_BIT];
    assign slot_ts[n*TS_W +: TS_W]  = uram_dout[n*SLOT_W+TS_LSB +: TS_W];
  end
  // victim is chosen straight off the read data so the write lands the cycle after capture
  slot_victim_sel u_sel (
    .valid_i (slot_v),
    .ts_i    (slot_ts),
    .idx_o   (victim)
  );
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    evt_d       = evt_q;
    evt_ready_d = 1'b0;
    nbr_valid_d = nbr_valid_q;
    nbr_row_d   = nbr_row_q;
    nbr_evt_d   = nbr_evt_q;
    init_done_d = init_done_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    din_d       = din_q;
    case (state_q)
      S_INIT: begin
        we_d   = 1'b1;
        addr_d = cnt_q;
        din_d  = '0;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(DEPTH-1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        init_done_d = 1'b1;
        evt_ready_d = 1'b1;
        if (evt_valid && evt_ready_q) begin
          evt_ready_d = 1'b0;
          evt_d       = evt_data;
          addr_d      = evt_addr;
          cnt_d       = '0;
          state_d     = S_READ;
        end
      end
      S_READ: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(RD_LAT)) begin
          we_d        = 1'b1;
          din_d       = put_slot(uram_dout, victim, evt_q);
          nbr_valid_d = 1'b1;
          nbr_row_d   = uram_dout;
          nbr_evt_d   = evt_q;
          state_d     = S_MODIFY;
        end
      end
      S_MODIFY, S_RESP: begin
        state_d = S_RESP;
        if (nbr_ready) begin
          nbr_valid_d = 1'b0;
          evt_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_INIT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      evt_q       <= '0;
      evt_ready_q <= 1'b0;
      nbr_valid_q <= 1'b0;
      nbr_row_q   <= '0;
      nbr_evt_q   <= '0;
      init_done_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      evt_q       <= evt_d;
      evt_ready_q <= evt_ready_d;
      nbr_valid_q <= nbr_valid_d;
      nbr_row_q   <= nbr_row_d;
      nbr_evt_q   <= nbr_evt_d;
      init_done_q <= init_done_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
    end
  end
  assign evt_ready = evt_ready_q;
  assign nbr_valid = nbr_valid_q;
  assign nbr_row   = nbr_row_q;
  assign nbr_evt   = nbr_evt_q;
  assign init_done = init_done_q;
  assign uram_we   = we_q;
  assign uram_addr = addr_q;
  assign uram_din  = din_q;
  addr_in_range: assert property (@(posedge clk) disable iff (!rstn)
    evt_valid |-> evt_addr < ADDR_W'(DEPTH));
endmodule

// File: tb/tb_cell_row_updater.sv
// tb_cell_row_updater: directed vectors against a behavioural URAM with RD_LAT read pipeline
module tb_cell_row_updater;
  import graph_build_pkg::*;
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [TS_W-1:0]   ts;
    int                slot;
    int                hold;
  } vec_t;
  logic              clk;
  logic              rstn;
  logic              evt_valid;
  logic              evt_ready;
  logic [ADDR_W-1:0] evt_addr;
  logic [EVT_W-1:0]  evt_data;
  logic              nbr_valid;
  logic              nbr_ready;
  logic [ROW_W-1:0]  nbr_row;
  logic [EVT_W-1:0]  nbr_evt;
  logic              init_done;
  logic              uram_we;
  logic [ADDR_W-1:0] uram_addr;
  logic [ROW_W-1:0]  uram_din;
  logic [ROW_W-1:0]  uram_dout;
  logic [ROW_W-1:0]  mem [DEPTH];
  logic [ROW_W-1:0]  pipe [RD_LAT];
  logic [ROW_W-1:0]  shadow [int];
  vec_t              tv [$];
  int                n_chk = 0;
  int                n_err = 0;
  int                we_cnt = 0;
  cell_row_updater dut (
    .clk       (clk),
    .rstn      (rstn),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_addr  (evt_addr),
    .evt_data  (evt_data),
    .nbr_valid (nbr_valid),
    .nbr_ready (nbr_ready),
    .nbr_row   (nbr_row),
    .nbr_evt   (nbr_evt),
    .init_done (init_done),
    .uram_we   (uram_we),
    .uram_addr (uram_addr),
    .uram_din  (uram_din),
    .uram_dout (uram_dout)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  assign uram_dout = pipe[RD_LAT-1];
  // stale junk is seeded into a few rows while reset is held, so the sweep must clear them
  always @(posedge clk) begin
    if (!rstn) begin
      mem[3]       <= '1;
      mem[5]       <= '1;
      mem[7]       <= '1;
      mem[20]      <= '1;
      mem[DEPTH-1] <= '1;
    end else if (uram_we) begin
      mem[uram_addr] <= uram_din;
    end
    if (uram_we) we_cnt <= we_cnt + 1;
    pipe[0] <= mem[uram_addr];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  task automatic chk(input string nm, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    int lane;
    n_chk++;
    if (act !== exp) begin
      n_err++;
      lane = 0;
      for (int i = NSLOT-1; i >= 0; i--)
        if (act[i*SLOT_W +: SLOT_W] !== exp[i*SLOT_W +: SLOT_W]) lane = i;
      $display("FAIL %s: lane %0d got %h expected %h", nm, lane,
               act[lane*SLOT_W +: SLOT_W], exp[lane*SLOT_W +: SLOT_W]);
    end
  endtask
  task automatic chk_reset_outputs();
    chk("rst_ctl", ROW_W'({evt_ready, nbr_valid, init_done, uram_we, uram_addr}), '0);
    chk("rst_din", uram_din, '0);
    chk("rst_nbr_row", nbr_row, '0);
    chk("rst_nbr_evt", ROW_W'(nbr_evt), '0);
  endtask
  function automatic logic [EVT_W-1:0] mk_evt(input logic [TS_W-1:0] ts);
    return {ts, 39'h12_3450_0000 ^ 39'(ts)};
  endfunction
  task automatic wait_ready();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (evt_ready) ok = 1'b1;
      else @(negedge clk);
    end
    chk("evt_ready_wait", ROW_W'(ok), ROW_W'(1));
  endtask
  task automatic do_evt(input vec_t v);
    logic [ROW_W-1:0] old_row, new_row;
    logic [EVT_W-1:0] e;
    int               w0;
    e       = mk_evt(v.ts);
    old_row = shadow.exists(int'(v.addr)) ? shadow[int'(v.addr)] : '0;
    new_row = old_row;
    new_row[v.slot*SLOT_W +: SLOT_W] = {1'b1, e};
    wait_ready();
    nbr_ready = (v.hold == 0);
    evt_valid = 1'b1;
    evt_addr  = v.addr;
    evt_data  = e;
    w0        = we_cnt;
    @(negedge clk);
    evt_valid = 1'b0;
    chk("rd_addr", ROW_W'(uram_addr), ROW_W'(v.addr));
    chk("rd_ctl", ROW_W'({evt_ready, uram_we, nbr_valid}), '0);
    repeat (RD_LAT) @(negedge clk);
    chk("early_nbr", ROW_W'({nbr_valid, uram_we}), '0);
    @(negedge clk);
    chk("wr_ctl", ROW_W'({uram_we, nbr_valid, evt_ready}), ROW_W'(3'b110));
    chk("wr_addr", ROW_W'(uram_addr), ROW_W'(v.addr));
    chk("wr_din", uram_din, new_row);
    chk("nbr_row", nbr_row, old_row);
    chk("nbr_evt", ROW_W'(nbr_evt), ROW_W'(e));
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      chk("bp_ctl", ROW_W'({nbr_valid, evt_ready, uram_we}), ROW_W'(3'b100));
      chk("bp_row", nbr_row, old_row);
      chk("bp_evt", ROW_W'(nbr_evt), ROW_W'(e));
    end
    nbr_ready = 1'b1;
    @(negedge clk);
    chk("release", ROW_W'({nbr_valid, evt_ready, uram_we}), ROW_W'(3'b010));
    chk("we_pulses", ROW_W'(we_cnt - w0), ROW_W'(1));
    shadow[int'(v.addr)] = new_row;
  endtask
  initial begin
    int bad;
    int w0;
    rstn      = 1'b0;
    evt_valid = 1'b0;
    evt_addr  = '0;
    evt_data  = '0;
    nbr_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rstn = 1'b1;
    bad  = 0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      if (!(uram_we && uram_addr == ADDR_W'(i) && uram_din == '0 && !init_done && !evt_ready))
        bad++;
    end
    chk("sweep_bad_cycles", ROW_W'(bad), '0);
    @(negedge clk);
    chk("init_done", ROW_W'({init_done, evt_ready, uram_we}), ROW_W'(3'b110));
    chk("row5_cleared", mem[5], '0);
    tv.push_back('{ADDR_W'(5), TS_W'(100), 0, 0});
    tv.push_back('{ADDR_W'(5), TS_W'(101), 1, 0});
    for (int i = 0; i < NSLOT; i++) tv.push_back('{ADDR_W'(7), TS_W'(10 + i), i, 0});
    tv.push_back('{ADDR_W'(7), TS_W'(26), 0, 0});
    for (int i = 0; i < NSLOT; i++)
      tv.push_back('{ADDR_W'(20), TS_W'((i == 3 || i == 9) ? 50 : 60 + i), i, 0});
    tv.push_back('{ADDR_W'(20), TS_W'(200), 3, 0});
    tv.push_back('{ADDR_W'(20), TS_W'(300), 9, 0});
    tv.push_back('{ADDR_W'(20), TS_W'(40), 0, 0});
    tv.push_back('{ADDR_W'(DEPTH-1), TS_W'(7), 0, 3});
    tv.push_back('{ADDR_W'(20), TS_W'(41), 0, 10});
    for (int i = 0; i < tv.size(); i++) do_evt(tv[i]);
    wait_ready();
    evt_valid = 1'b1;
    evt_addr  = ADDR_W'(3);
    evt_data  = mk_evt(TS_W'(9));
    w0        = we_cnt;
    @(negedge clk);
    evt_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk_reset_outputs();
    chk("mid_rst_no_write", ROW_W'(we_cnt - w0), '0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("resweep_start", ROW_W'({uram_we, uram_addr}), ROW_W'({1'b1, ADDR_W'(0)}));
    for (int i = 0; i < DEPTH + 10 && !init_done; i++) @(negedge clk);
    chk("resweep_done", ROW_W'({init_done, evt_ready}), ROW_W'(2'b11));
    chk("row3_cleared", mem[3], '0);
    shadow.delete();
    do_evt('{ADDR_W'(7), TS_W'(5), 0, 0});
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end
endmodule
